// File: rtl/ir_pkg.sv
// Shared types and constants for the HT6221/NEC key controller: event codes,
// one-hot FSM encoding, default 50 MHz timing and the frame complement check.
package ir_pkg;

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'd0,
    EVT_REPEAT  = 2'd1,
    EVT_RELEASE = 2'd2
  } evt_type_e;

  typedef enum logic [4:0] {
    S_IDLE    = 5'b00001,
    S_CHECK   = 5'b00010,
    S_PRESS   = 5'b00100,
    S_HELD    = 5'b01000,
    S_RELEASE = 5'b10000
  } state_e;

  localparam int unsigned TMR_W             = 26;
  localparam int unsigned RELEASE_TO_DEF    = 6_000_000;   // 120 ms
  localparam int unsigned REPEAT_DLY_DEF    = 25_000_000;  // 500 ms
  localparam int unsigned REPEAT_PERIOD_DEF = 5_000_000;   // 100 ms
  localparam logic [7:0]  NEC_MASK          = 8'hFF;

  // NEC frames carry the command in [7:0] and its bitwise inverse in [15:8].
  function automatic logic nec_ok(input logic [15:0] data);
    return (data[7:0] ^ data[15:8]) == NEC_MASK;
  endfunction

endpackage

// File: rtl/ir_edge_sync.sv
// Two-flop synchroniser for the idle-high IR line plus a falling-edge pulse.
// Flops reset to 1 so that leaving reset never fakes an edge.
module ir_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic fall
);

  logic sync0, sync1;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync0 <= 1'b1;
      sync1 <= 1'b1;
    end else begin
      sync0 <= din;
      sync1 <= sync0;
    end
  end

  assign fall = sync1 & ~sync0;

endmodule

// File: rtl/ir_key_ctrl.sv
// Turns decoded HT6221 frames plus raw IR activity into PRESS/REPEAT/RELEASE
// events on a one-deep valid/ready slot. Define IR_ADDR_FILTER_EN to reject
// frames whose address differs from DEV_ADDR.
module ir_key_ctrl
  import ir_pkg::*;
#(
  parameter logic [15:0] DEV_ADDR      = 16'hFF00,
  parameter int unsigned RELEASE_TO    = RELEASE_TO_DEF,
  parameter int unsigned REPEAT_DLY    = REPEAT_DLY_DEF,
  parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ir_in,
  input  logic        dec_valid,
  input  logic [15:0] dec_data,
  input  logic [15:0] dec_addr,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [1:0]  evt_type,
  output logic [7:0]  evt_code,
  output logic [15:0] evt_addr,
  output logic        key_held,
  output logic [7:0]  err_cnt,
  output logic        ovf,
  input  logic        ovf_clr
);

`ifdef IR_ADDR_FILTER_EN
  localparam bit ADDR_FILTER = 1'b1;
`else
  localparam bit ADDR_FILTER = 1'b0;
`endif

  localparam logic [TMR_W-1:0] REL_LAST   = TMR_W'(RELEASE_TO - 1);
  localparam logic [TMR_W-1:0] DLY_LAST   = TMR_W'(REPEAT_DLY - 1);
  localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD - 1);

  state_e           state;
  logic             ir_fall;
  logic [15:0]      fr_data, fr_addr;
  logic [7:0]       held_code;
  logic [15:0]      held_addr;
  logic             pend_press;
  logic [TMR_W-1:0] rel_tmr, rep_tmr;
  logic             rep_first;

  logic slot_free, frame_ok, rel_hit, rep_hit, releasing;

  ir_edge_sync u_edge_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (ir_in),
    .fall (ir_fall)
  );

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    frame_ok = nec_ok(fr_data);
    if (ADDR_FILTER && (fr_addr != DEV_ADDR)) frame_ok = 1'b0;
  end

  assign slot_free = !evt_valid || evt_ready;
  assign rel_hit   = (rel_tmr == REL_LAST);
  assign rep_hit   = (rep_tmr == (rep_first ? DLY_LAST : PERIOD_LAST));
  // Activity in the same cycle as a timeout keeps the key alive.
  assign releasing = rel_hit && !ir_fall && !dec_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      fr_data    <= '0;
      fr_addr    <= '0;
      held_code  <= '0;
      held_addr  <= '0;
      pend_press <= 1'b0;
      rel_tmr    <= '0;
      rep_tmr    <= '0;
      rep_first  <= 1'b1;
      evt_valid  <= 1'b0;
      evt_type   <= '0;
      evt_code   <= '0;
      evt_addr   <= '0;
      key_held   <= 1'b0;
      err_cnt    <= '0;
      ovf        <= 1'b0;
    end else begin
      // Defaults first; a later load or overflow in this block overrides them.
      if (evt_valid && evt_ready) evt_valid <= 1'b0;
      if (ovf_clr) ovf <= 1'b0;

      case (state)
        S_IDLE: begin
          if (dec_valid) begin
            fr_data <= dec_data;
            fr_addr <= dec_addr;
            state   <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (dec_valid) ovf <= 1'b1;
          if (!frame_ok) begin
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            state <= key_held ? S_HELD : S_IDLE;
          end else if (!key_held) begin
            state <= S_PRESS;
          end else if (fr_data[7:0] == held_code) begin
            rel_tmr <= '0;
            state   <= S_HELD;
          end else begin
            pend_press <= 1'b1;
            state      <= S_RELEASE;
          end
        end

        S_PRESS: begin
          if (dec_valid) ovf <= 1'b1;
          if (slot_free) begin
            evt_valid  <= 1'b1;
            evt_type   <= EVT_PRESS;
            evt_code   <= fr_data[7:0];
            evt_addr   <= fr_addr;
            held_code  <= fr_data[7:0];
            held_addr  <= fr_addr;
            key_held   <= 1'b1;
            pend_press <= 1'b0;
            rel_tmr    <= '0;
            rep_tmr    <= '0;
            rep_first  <= 1'b1;
            state      <= S_HELD;
          end
        end

        S_HELD: begin
          if (dec_valid) begin
            fr_data <= dec_data;
            fr_addr <= dec_addr;
            state   <= S_CHECK;
          end else if (ir_fall) begin
            rel_tmr <= '0;
          end else if (rel_hit) begin
            state <= S_RELEASE;
          end else begin
            rel_tmr <= rel_tmr + TMR_W'(1);
          end

          if (!releasing) begin
            if (rep_hit) begin
              rep_tmr   <= '0;
              rep_first <= 1'b0;
              if (slot_free) begin
                evt_valid <= 1'b1;
                evt_type  <= EVT_REPEAT;
                evt_code  <= held_code;
                evt_addr  <= held_addr;
              end else begin
                ovf <= 1'b1;
              end
            end else begin
              rep_tmr <= rep_tmr + TMR_W'(1);
            end
          end
        end

        S_RELEASE: begin
          if (dec_valid) ovf <= 1'b1;
          if (slot_free) begin
            evt_valid <= 1'b1;
            evt_type  <= EVT_RELEASE;
            evt_code  <= held_code;
            evt_addr  <= held_addr;
            key_held  <= 1'b0;
            state     <= pend_press ? S_PRESS : S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ir_key_ctrl.sv
// Directed bench for ir_key_ctrl with shortened timers; a negedge monitor logs
// every accepted event so each scenario can check order, codes and timing.
module tb_ir_key_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ir_in = 1'b1;
  logic        dec_valid = 1'b0;
  logic [15:0] dec_data = '0;
  logic [15:0] dec_addr = '0;
  logic        evt_valid;
  logic        evt_ready = 1'b1;
  logic [1:0]  evt_type;
  logic [7:0]  evt_code;
  logic [15:0] evt_addr;
  logic        key_held;
  logic [7:0]  err_cnt;
  logic        ovf;
  logic        ovf_clr = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [1:0]  t;
    logic [7:0]  c;
    logic [15:0] a;
    int          cyc;
  } ev_t;
  ev_t evq[$];

  ir_key_ctrl #(
    .DEV_ADDR      (16'hFF00),
    .RELEASE_TO    (1000),
    .REPEAT_DLY    (3000),
    .REPEAT_PERIOD (1000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ir_in     (ir_in),
    .dec_valid (dec_valid),
    .dec_data  (dec_data),
    .dec_addr  (dec_addr),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_type  (evt_type),
    .evt_code  (evt_code),
    .evt_addr  (evt_addr),
    .key_held  (key_held),
    .err_cnt   (err_cnt),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk)
    if (!rst && evt_valid && evt_ready) evq.push_back('{evt_type, evt_code, evt_addr, cyc});

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick(1);
  endtask

  task automatic send_frame(input logic [15:0] data, input logic [15:0] addr);
    dec_data  = data;
    dec_addr  = addr;
    dec_valid = 1'b1;
    tick(1);
    dec_valid = 1'b0;
  endtask

  task automatic ir_pulse();
    ir_in = 1'b0;
    tick(4);
    ir_in = 1'b1;
  endtask

  task automatic wait_release(input int budget);
    int n = 0;
    while (key_held && n < budget) begin
      tick(1);
      n++;
    end
    checks++;
    if (key_held !== 1'b0) begin
      errors++;
      $display("FAIL release_timeout: key_held still %0b after %0d cycles", key_held, budget);
    end
    tick(3);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL rst_evt_valid: got %0b expected 0", evt_valid); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL rst_key_held: got %0b expected 0", key_held); end
    checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL rst_err_cnt: got %h expected 00", err_cnt); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %0b expected 0", ovf); end
    checks++; if (evt_code !== 8'h00) begin errors++; $display("FAIL rst_evt_code: got %h expected 00", evt_code); end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_bad_frame();
    evq.delete();
    send_frame(16'hBB45, 16'hFF00);
    tick(6);
    checks++; if (evq.size() !== 0) begin errors++; $display("FAIL bad_no_event: got %0d events expected 0", evq.size()); end
    checks++; if (err_cnt !== 8'h01) begin errors++; $display("FAIL bad_err_cnt: got %h expected 01", err_cnt); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL bad_key_held: got %0b expected 0", key_held); end
  endtask

  task automatic test_addr();
    evq.delete();
    send_frame(16'hBA45, 16'h1234);
    tick(6);
`ifdef IR_ADDR_FILTER_EN
    checks++; if (evq.size() !== 0) begin errors++; $display("FAIL addr_no_event: got %0d events expected 0", evq.size()); end
    checks++; if (err_cnt !== 8'h02) begin errors++; $display("FAIL addr_err_cnt: got %h expected 02", err_cnt); end
`else
    checks++; if (evq.size() !== 1) begin errors++; $display("FAIL addr_event_count: got %0d expected 1", evq.size()); end
    if (evq.size() >= 1) begin
      checks++; if (evq[0].a !== 16'h1234) begin errors++; $display("FAIL addr_evt_addr: got %h expected 1234", evq[0].a); end
    end
    checks++; if (err_cnt !== 8'h01) begin errors++; $display("FAIL addr_err_cnt: got %h expected 01", err_cnt); end
    wait_release(2000);
`endif
  endtask

  task automatic test_press_release();
    evq.delete();
    send_frame(16'hBA45, 16'hFF00);
    tick(1);
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL press_early: evt_valid %0b at 2 cycles expected 0", evt_valid); end
    tick(1);
    checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL press_latency: evt_valid %0b at 3 cycles expected 1", evt_valid); end
    checks++; if (evt_type !== 2'd0) begin errors++; $display("FAIL press_type: got %0d expected 0", evt_type); end
    checks++; if (evt_code !== 8'h45) begin errors++; $display("FAIL press_code: got %h expected 45", evt_code); end
    checks++; if (evt_addr !== 16'hFF00) begin errors++; $display("FAIL press_addr: got %h expected ff00", evt_addr); end
    tick(500);
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL hold_key_held: got %0b expected 1", key_held); end
    wait_release(1500);
    checks++; if (evq.size() !== 2) begin errors++; $display("FAIL pr_event_count: got %0d expected 2", evq.size()); end
    if (evq.size() >= 2) begin
      checks++; if (evq[1].t !== 2'd2 || evq[1].c !== 8'h45) begin errors++; $display("FAIL pr_release: got type %0d code %h expected 2 45", evq[1].t, evq[1].c); end
      checks++;
      if ((evq[1].cyc - evq[0].cyc) < 995 || (evq[1].cyc - evq[0].cyc) > 1005) begin
        errors++; $display("FAIL pr_release_time: got %0d cycles expected about 1000", evq[1].cyc - evq[0].cyc);
      end
    end
  endtask

  task automatic test_repeat();
    int t0;
    evq.delete();
    send_frame(16'hBA45, 16'hFF00);
    tick(2);
    t0 = cyc;
    for (int k = 1; k <= 11; k++) begin
      wait_until(t0 + 500 * k);
      ir_pulse();
    end
    wait_release(3000);
    checks++; if (evq.size() !== 6) begin errors++; $display("FAIL rep_event_count: got %0d expected 6", evq.size()); end
    if (evq.size() >= 6) begin
      for (int i = 1; i <= 4; i++) begin
        checks++;
        if (evq[i].t !== 2'd1 || evq[i].c !== 8'h45 || (evq[i].cyc - evq[0].cyc) !== 2000 + 1000 * i) begin
          errors++;
          $display("FAIL rep_%0d: got type %0d code %h at +%0d expected 1 45 at +%0d",
                   i, evq[i].t, evq[i].c, evq[i].cyc - evq[0].cyc, 2000 + 1000 * i);
        end
      end
      checks++;
      if (evq[5].t !== 2'd2 || (evq[5].cyc - evq[0].cyc) < 6450 || (evq[5].cyc - evq[0].cyc) > 6550) begin
        errors++; $display("FAIL rep_release: got type %0d at +%0d expected 2 near +6500", evq[5].t, evq[5].cyc - evq[0].cyc);
      end
    end
  endtask

  task automatic test_code_change();
    evq.delete();
    send_frame(16'hBA45, 16'hFF00);
    tick(20);
    send_frame(16'hB946, 16'hFF00);
    tick(10);
    checks++; if (evq.size() !== 3) begin errors++; $display("FAIL chg_event_count: got %0d expected 3", evq.size()); end
    if (evq.size() >= 3) begin
      checks++; if (evq[1].t !== 2'd2 || evq[1].c !== 8'h45) begin errors++; $display("FAIL chg_release_old: got type %0d code %h expected 2 45", evq[1].t, evq[1].c); end
      checks++; if (evq[2].t !== 2'd0 || evq[2].c !== 8'h46) begin errors++; $display("FAIL chg_press_new: got type %0d code %h expected 0 46", evq[2].t, evq[2].c); end
    end
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL chg_key_held: got %0b expected 1", key_held); end
    wait_release(2000);
  endtask

  task automatic test_back_to_back();
    int t0;
    evq.delete();
    evt_ready = 1'b0;
    send_frame(16'hB847, 16'hFF00);
    tick(2);
    t0 = cyc;
    for (int k = 1; k <= 7; k++) begin
      wait_until(t0 + 500 * k);
      ir_pulse();
    end
    wait_until(t0 + 4990);
    checks++; if (evt_valid !== 1'b1 || evt_type !== 2'd0 || evt_code !== 8'h47) begin
      errors++; $display("FAIL bp_press_stable: got valid %0b type %0d code %h expected 1 0 47", evt_valid, evt_type, evt_code); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL bp_ovf_set: got %0b expected 1", ovf); end
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL bp_release_stall: key_held %0b expected 1", key_held); end
    evt_ready = 1'b1;
    tick(4);
    checks++; if (evq.size() !== 2) begin errors++; $display("FAIL bp_event_count: got %0d expected 2", evq.size()); end
    if (evq.size() >= 2) begin
      checks++; if (evq[0].t !== 2'd0 || evq[1].t !== 2'd2 || evq[1].c !== 8'h47) begin
        errors++; $display("FAIL bp_order: got types %0d %0d code %h expected 0 2 47", evq[0].t, evq[1].t, evq[1].c); end
      checks++; if ((evq[1].cyc - evq[0].cyc) !== 1) begin
        errors++; $display("FAIL bp_zero_bubble: got gap %0d expected 1", evq[1].cyc - evq[0].cyc); end
    end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL bp_key_released: got %0b expected 0", key_held); end
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL bp_ovf_clr: got %0b expected 0", ovf); end
  endtask

  task automatic test_reset_mid_hold();
    evq.delete();
    evt_ready = 1'b0;
    send_frame(16'hBA45, 16'hFF00);
    tick(50);
    rst = 1'b1;
    tick(1);
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_evt_valid: got %0b expected 0", evt_valid); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL mid_rst_key_held: got %0b expected 0", key_held); end
    rst = 1'b0;
    evt_ready = 1'b1;
    tick(2000);
    checks++; if (evq.size() !== 0) begin errors++; $display("FAIL mid_rst_no_release: got %0d events expected 0", evq.size()); end
  endtask

  initial begin
    test_reset();
    test_bad_frame();
    test_addr();
    test_press_release();
    test_repeat();
    test_code_change();
    test_back_to_back();
    test_reset_mid_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
